rally_judge: RTL

RALLY_JUDGE -- requirements
Module: rally_judge

---
 rtl/blobby_pkg.sv | 24 ++
 rtl/collision_edge.sv | 28 ++
 rtl/rally_judge.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/blobby_pkg.sv
// Shared types and defaults for the blobby volley rally judge.
// Holds state encoding, side encoding and default court geometry.
package blobby_pkg;

    typedef enum logic [1:0] {
        ST_SERVE   = 2'd0,
        ST_RALLY   = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_ENDGAME = 2'd3
    } state_t;

    typedef enum logic {
        SIDE_P1 = 1'b0,
        SIDE_P2 = 1'b1
    } side_t;

    localparam int NET_X_DEF    = 511;
    localparam int GROUND_Y_DEF = 679;

    function automatic side_t other_side(input side_t s);
        return (s == SIDE_P1) ? SIDE_P2 : SIDE_P1;
    endfunction

endpackage

// File: rtl/collision_edge.sv
// Rising-edge detector for one player's collision level.
// Ports: clk, rst (async high), level in, rise out (level & !previous).
module collision_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = level;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    // prev resets low, so a level held through reset release is an edge
    assign rise = level & ~prev_q;

endmodule

// File: rtl/rally_judge.sv
// Rally referee: tracks serve, touches, faults, scores and game end.
// Ports: clk, rst, ball x/y, player collisions, new_game in;
//        scores, serve_side, rally_active, point_pulse/point_to,
//        game_over, winner out (all registered).
module rally_judge
    import blobby_pkg::*;
#(
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 15,
    parameter int WIN_MARGIN   = 1,
    parameter int MAX_TOUCHES  = 3,
    parameter int NET_X        = NET_X_DEF,
    parameter int GROUND_Y     = GROUND_Y_DEF,
    parameter int PAUSE_CYCLES = 650000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [11:0]        xposball,
    input  logic [11:0]        yposball,
    input  logic               collisionsplayer1,
    input  logic               collisionsplayer2,
    input  logic               new_game,
    output logic [SCORE_W-1:0] score_player1,
    output logic [SCORE_W-1:0] score_player2,
    output logic               serve_side,
    output logic               rally_active,
    output logic               point_pulse,
    output logic               point_to,
    output logic               game_over,
    output logic               winner
);

    localparam int CW  = $clog2(MAX_TOUCHES + 2);
    localparam int PW  = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam int SW1 = SCORE_W + 1;

    localparam logic [CW-1:0]      T_LIM    = CW'(MAX_TOUCHES + 1);
    localparam logic [PW-1:0]      P_LOAD   = PW'(PAUSE_CYCLES - 1);
    localparam logic [SCORE_W-1:0] S_MAX    = '1;
    localparam logic [SCORE_W:0]   WIN_L    = SW1'(WIN_SCORE);
    localparam logic [SCORE_W:0]   MARGIN_L = SW1'(WIN_MARGIN);
    localparam logic [11:0]        NET_L    = 12'(NET_X);
    localparam logic [11:0]        GND_L    = 12'(GROUND_Y);

    state_t             state_q,  state_d;
    logic [SCORE_W-1:0] s1_q,     s1_d;
    logic [SCORE_W-1:0] s2_q,     s2_d;
    logic [CW-1:0]      c1_q,     c1_d;
    logic [CW-1:0]      c2_q,     c2_d;
    logic [PW-1:0]      pause_q,  pause_d;
    side_t              serve_q,  serve_d;
    side_t              pt_q,     pt_d;
    side_t              win_q,    win_d;
    logic               pulse_q,  pulse_d;
    logic               go_q,     go_d;
    logic               active_q, active_d;

    logic          e1, e2;
    logic          srv_edge;
    logic [CW-1:0] n1, n2;
    logic          f1, f2;
    logic          hit;
    side_t         to;

    collision_edge u_edge_p1 (
        .clk   (clk),
        .rst   (rst),
        .level (collisionsplayer1),
        .rise  (e1)
    );

    collision_edge u_edge_p2 (
        .clk   (clk),
        .rst   (rst),
        .level (collisionsplayer2),
        .rise  (e2)
    );

    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
        return (c == T_LIM) ? c : c + CW'(1);
    endfunction

    function automatic logic [SCORE_W-1:0] sc_inc(
        input logic [SCORE_W-1:0] s
    );
        return (s == S_MAX) ? s : s + SCORE_W'(1);
    endfunction

    function automatic logic wins(
        input logic [SCORE_W-1:0] a,
        input logic [SCORE_W-1:0] b
    );
        return ({1'b0, a} >= WIN_L && {1'b0, a} >= {1'b0, b} + MARGIN_L)
            || a == S_MAX;
    endfunction

    always_comb begin
        state_d  = state_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        c1_d     = c1_q;
        c2_d     = c2_q;
        pause_d  = pause_q;
        serve_d  = serve_q;
        pt_d     = pt_q;
        win_d    = win_q;
        go_d     = go_q;
        pulse_d  = 1'b0;
        srv_edge = (serve_q == SIDE_P1) ? e1 : e2;
        n1       = c1_q;
        n2       = c2_q;
        f1       = 1'b0;
        f2       = 1'b0;
        hit      = 1'b0;
        to       = SIDE_P1;

        if (new_game) begin
            state_d = ST_SERVE;
            s1_d    = '0;
            s2_d    = '0;
            c1_d    = '0;
            c2_d    = '0;
            pause_d = '0;
            serve_d = SIDE_P1;
            go_d    = 1'b0;
            win_d   = SIDE_P1;
        end else begin
            unique case (state_q)
                ST_SERVE: begin
                    if (srv_edge) begin
                        state_d = ST_RALLY;
                        c1_d = (serve_q == SIDE_P1) ? CW'(1) : CW'(0);
                        c2_d = (serve_q == SIDE_P2) ? CW'(1) : CW'(0);
                    end
                end
                ST_RALLY: begin
                    // same-cycle touches both count; neither clears the other
                    if (e1 && e2) begin
                        n1 = cnt_inc(c1_q);
                        n2 = cnt_inc(c2_q);
                    end else if (e1) begin
                        n1 = cnt_inc(c1_q);
                        n2 = '0;
                    end else if (e2) begin
                        n1 = '0;
                        n2 = cnt_inc(c2_q);
                    end
                    f1   = (n1 == T_LIM);
                    f2   = (n2 == T_LIM);
                    c1_d = n1;
                    c2_d = n2;
                    if (yposball >= GND_L) begin
                        hit = 1'b1;
                        to  = (xposball < NET_L) ? SIDE_P2 : SIDE_P1;
                    end else if (f1 && f2) begin
                        c1_d = '0;
                        c2_d = '0;
                    end else if (f1) begin
                        hit = 1'b1;
                        to  = other_side(SIDE_P1);
                    end else if (f2) begin
                        hit = 1'b1;
                        to  = other_side(SIDE_P2);
                    end
                    if (hit) begin
                        if (to == SIDE_P1) begin
                            s1_d = sc_inc(s1_q);
                        end else begin
                            s2_d = sc_inc(s2_q);
                        end
                        pt_d    = to;
                        pulse_d = 1'b1;
                        state_d = ST_PAUSE;
                        pause_d = P_LOAD;
                        c1_d    = '0;
                        c2_d    = '0;
                    end
                end
                ST_PAUSE: begin
                    if (pause_q == '0) begin
                        if (wins(s1_q, s2_q) || wins(s2_q, s1_q)) begin
                            state_d = ST_ENDGAME;
                            go_d    = 1'b1;
                            win_d   = wins(s1_q, s2_q) ? SIDE_P1 : SIDE_P2;
                        end else begin
                            state_d = ST_SERVE;
                            serve_d = pt_q;
                        end
                    end else begin
                        pause_d = pause_q - PW'(1);
                    end
                end
                ST_ENDGAME: begin
                end
                default: begin
                    state_d = ST_SERVE;
                end
            endcase
        end

        active_d = (state_d == ST_RALLY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_SERVE;
            s1_q     <= '0;
            s2_q     <= '0;
            c1_q     <= '0;
            c2_q     <= '0;
            pause_q  <= '0;
            serve_q  <= SIDE_P1;
            pt_q     <= SIDE_P1;
            win_q    <= SIDE_P1;
            pulse_q  <= 1'b0;
            go_q     <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            c1_q     <= c1_d;
            c2_q     <= c2_d;
            pause_q  <= pause_d;
            serve_q  <= serve_d;
            pt_q     <= pt_d;
            win_q    <= win_d;
            pulse_q  <= pulse_d;
            go_q     <= go_d;
            active_q <= active_d;
        end
    end

    assign score_player1 = s1_q;
    assign score_player2 = s2_q;
    assign serve_side    = serve_q;
    assign rally_active  = active_q;
    assign point_pulse   = pulse_q;
    assign point_to      = pt_q;
    assign game_over     = go_q;
    assign winner        = win_q;

endmodule
